// File: rtl/pe_array_seq_ctrl.sv
// Sequencer for one column-chain of PE_16 processing elements.
// Per command: reads ROWS weight words (driving the chain's is_weight),
// streams num_vec activation vectors, then flags which chain-output cycles
// carry valid sums. Owns the read ports of the weight and activation buffers.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_simd_mode            0 = 8-bit SIMD, 1 = 16-bit; latched at accept
//   cmd_num_vec              vectors to stream; latched at accept
//   abort                    cancel running command (ignored in IDLE)
//   w_rd_en/w_rd_addr        weight-buffer read port
//   a_rd_en/a_rd_addr        activation-buffer read port
//   arr_is_weight            to chain, aligned with 1-cycle buffer read data
//   arr_simd_mode            to chain, latched mode
//   res_valid/res_idx        chain sum_out is valid / its vector index
//   busy, done               status; done pulses once on normal completion
module pe_array_seq_ctrl #(
    parameter int ROWS  = 4,
    parameter int AW    = 8,
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_simd_mode,
    input  logic [VEC_W-1:0] cmd_num_vec,
    input  logic             abort,
    output logic             w_rd_en,
    output logic [AW-1:0]    w_rd_addr,
    output logic             a_rd_en,
    output logic [AW-1:0]    a_rd_addr,
    output logic             arr_is_weight,
    output logic             arr_simd_mode,
    output logic             res_valid,
    output logic [VEC_W-1:0] res_idx,
    output logic             busy,
    output logic             done
);

    // Counter must cover weight rows, vector count and address width.
    localparam int RW  = $clog2(ROWS + 1);
    localparam int CW0 = (AW > VEC_W) ? AW : VEC_W;
    localparam int CW  = (CW0 > RW) ? CW0 : RW;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             simd_q;
    logic [VEC_W-1:0] num_vec_q;

    // vld_pipe[k] holds a_rd_en from k+1 cycles ago; idx_pipe follows it.
    logic [ROWS:0]    vld_pipe;
    logic [VEC_W-1:0] idx_pipe [ROWS+1];
    logic             w_pipe;

    logic accept, kill, last_w, last_a, pending;

    assign accept  = cmd_valid & cmd_ready;
    assign kill    = abort & (state != IDLE);
    assign last_w  = (cnt == CW'(ROWS - 1));
    assign last_a  = (cnt == (CW'(num_vec_q) - CW'(1)));
    // Anything still in flight behind the entry currently at the output.
    assign pending = |vld_pipe[ROWS-1:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD_W;
            LOAD_W:  if (last_w) state_nx = (num_vec_q == '0) ? DRAIN : STREAM;
            STREAM:  if (last_a) state_nx = DRAIN;
            DRAIN:   if (!pending) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == DONE);
        w_rd_en   = (state == LOAD_W);
        a_rd_en   = (state == STREAM);
        w_rd_addr = w_rd_en ? cnt[AW-1:0] : '0;
        a_rd_addr = a_rd_en ? cnt[AW-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            simd_q    <= 1'b0;
            num_vec_q <= '0;
            vld_pipe  <= '0;
            w_pipe    <= 1'b0;
            for (int k = 0; k <= ROWS; k++) idx_pipe[k] <= '0;
        end else begin
            state <= state_nx;
            // Counter restarts on every state change so each phase counts from 0.
            if (state_nx != state)
                cnt <= '0;
            else if (state == LOAD_W || state == STREAM)
                cnt <= cnt + CW'(1);
            if (accept) begin
                simd_q    <= cmd_simd_mode;
                num_vec_q <= cmd_num_vec;
            end
            if (kill) begin
                // Flush includes the read issued in the abort cycle itself.
                vld_pipe <= '0;
                w_pipe   <= 1'b0;
                for (int k = 0; k <= ROWS; k++) idx_pipe[k] <= '0;
            end else begin
                vld_pipe    <= {vld_pipe[ROWS-1:0], a_rd_en};
                w_pipe      <= w_rd_en;
                idx_pipe[0] <= a_rd_en ? cnt[VEC_W-1:0] : '0;
                for (int k = 1; k <= ROWS; k++) idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    assign arr_is_weight = w_pipe;
    assign arr_simd_mode = simd_q;
    assign res_valid     = vld_pipe[ROWS];
    assign res_idx       = res_valid ? idx_pipe[ROWS] : '0;

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
module tb_pe_array_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, cmd_simd_mode, abort;
    logic [7:0] cmd_num_vec;
    logic       w_rd_en, a_rd_en, arr_is_weight, arr_simd_mode, res_valid, busy, done;
    logic [7:0] w_rd_addr, a_rd_addr, res_idx;

    int checks = 0;
    int errors = 0;

    pe_array_seq_ctrl #(.ROWS(4), .AW(8), .VEC_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_simd_mode(cmd_simd_mode), .cmd_num_vec(cmd_num_vec), .abort(abort),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .arr_is_weight(arr_is_weight), .arr_simd_mode(arr_simd_mode),
        .res_valid(res_valid), .res_idx(res_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   32'(cmd_ready), 1);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_wen"},   32'(w_rd_en), 0);
        chk({tag, "_waddr"}, 32'(w_rd_addr), 0);
        chk({tag, "_aen"},   32'(a_rd_en), 0);
        chk({tag, "_aaddr"}, 32'(a_rd_addr), 0);
        chk({tag, "_isw"},   32'(arr_is_weight), 0);
        chk({tag, "_simd"},  32'(arr_simd_mode), 0);
        chk({tag, "_rv"},    32'(res_valid), 0);
        chk({tag, "_idx"},   32'(res_idx), 0);
    endtask

    // Expected trace with accept in cycle 0 and ROWS = 4:
    // weights 1..4, is_weight 2..5, reads 5..4+n, results 10..9+n.
    task automatic check_cycle(input int t, input int n, input logic simd, input int dt);
        int e_w, e_isw, e_a, e_rv, e_busy;
        e_w    = (t >= 1 && t <= 4) ? 1 : 0;
        e_isw  = (t >= 2 && t <= 5) ? 1 : 0;
        e_a    = (n > 0 && t >= 5 && t <= 4 + n) ? 1 : 0;
        e_rv   = (n > 0 && t >= 10 && t <= 9 + n) ? 1 : 0;
        e_busy = (t >= 1 && t <= dt) ? 1 : 0;
        chk("w_en",    32'(w_rd_en), 32'(e_w));
        chk("w_addr",  32'(w_rd_addr), 32'((e_w != 0) ? t - 1 : 0));
        chk("is_w",    32'(arr_is_weight), 32'(e_isw));
        chk("a_en",    32'(a_rd_en), 32'(e_a));
        chk("a_addr",  32'(a_rd_addr), 32'((e_a != 0) ? t - 5 : 0));
        chk("res_v",   32'(res_valid), 32'(e_rv));
        chk("res_idx", 32'(res_idx), 32'((e_rv != 0) ? t - 10 : 0));
        chk("busy",    32'(busy), 32'(e_busy));
        chk("ready",   32'(cmd_ready), 32'(1 - e_busy));
        chk("done",    32'(done), 32'((t == dt) ? 1 : 0));
        chk("simd",    32'(arr_simd_mode), 32'(simd));
        chk("overlap", 32'(w_rd_en & a_rd_en), 0);
    endtask

    // Starts in an IDLE cycle; leaves the bench in the first IDLE cycle after done.
    task automatic run_cmd(input logic simd, input int n, input logic hold, input logic ab0);
        int dt;
        dt = (n == 0) ? 6 : 10 + n;
        cmd_valid     = 1'b1;
        cmd_simd_mode = simd;
        cmd_num_vec   = 8'(n);
        abort         = ab0;
        chk("accept_rdy", 32'(cmd_ready), 1);
        step();
        abort         = 1'b0;
        cmd_valid     = hold;
        cmd_simd_mode = ~simd;
        for (int t = 1; t <= dt; t++) begin
            check_cycle(t, n, simd, dt);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_simd_mode = 1'b0; cmd_num_vec = '0; abort = 1'b0;
        step(); step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        // Basic command: simd=1, n=3; mode toggled while busy inside run_cmd.
        run_cmd(1'b1, 3, 1'b0, 1'b0);
        // No vectors: weights only, then done.
        run_cmd(1'b0, 0, 1'b0, 1'b0);
        // Abort in IDLE coinciding with a command: accepted.
        run_cmd(1'b1, 1, 1'b0, 1'b1);

        // Abort after 2 of 5 activation reads.
        cmd_valid = 1'b1; cmd_simd_mode = 1'b0; cmd_num_vec = 8'd5;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("ab_a_en5", 32'(a_rd_en), 1);
        chk("ab_addr5", 32'(a_rd_addr), 0);
        step();
        chk("ab_a_en6", 32'(a_rd_en), 1);
        chk("ab_addr6", 32'(a_rd_addr), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("ab_a_en", 32'(a_rd_en), 0);
            chk("ab_rv",   32'(res_valid), 0);
            chk("ab_done", 32'(done), 0);
            chk("ab_busy", 32'(busy), 0);
            chk("ab_isw",  32'(arr_is_weight), 0);
            step();
        end

        // Reset while in DRAIN (n=2: DRAIN spans cycles 7..11).
        cmd_valid = 1'b1; cmd_simd_mode = 1'b1; cmd_num_vec = 8'd2;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("rd_busy", 32'(busy), 1);
        chk("rd_aen",  32'(a_rd_en), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("rst_drain");
        for (int i = 0; i < 8; i++) begin
            chk("rd_rv",   32'(res_valid), 0);
            chk("rd_done", 32'(done), 0);
            step();
        end
        run_cmd(1'b1, 3, 1'b0, 1'b0);

        // Back-to-back with cmd_valid held high.
        run_cmd(1'b0, 2, 1'b1, 1'b0);
        run_cmd(1'b1, 0, 1'b1, 1'b0);
        run_cmd(1'b0, 1, 1'b0, 1'b0);

        // Maximum vector count.
        run_cmd(1'b1, 255, 1'b0, 1'b0);
        chk("end_rdy",  32'(cmd_ready), 1);
        chk("end_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
